lsu_ctrl: RTL

Load/store control unit sitting directly upstream of the data memory (DMEM) in the RISC-V core's MEM stage. Accepts one load/store request at a time from EX over a valid/ready handshake and checks size, alignment and address range. It drives DMEM's control inputs (write_en, size, sign_extend, addr, write_data) for exactly one cycle, captures DMEM's combinational read data, and returns a registered response to writeback over a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 12 +
 rtl/lsu_align_check.sv | 25 ++
 rtl/lsu_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, error codes and FSM state type for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ACCESS   = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: combinational size/alignment/range check of a load/store request.
// Ports: size, addr in; err (request faults), err_code (highest-priority fault) out.
module lsu_align_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  output logic        err,
  output logic [1:0]  err_code
);
  logic [32:0] off;
  logic        mis;
  logic        oor;
  always_comb begin
    // Bit 32 of the widened difference flags addresses below DMEM_BASE.
    off      = {1'b0, addr} - {1'b0, DMEM_BASE};
    mis      = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
    oor      = off[32] || (off[31:0] >= 32'(DMEM_BYTES));
    err_code = size == SZ_ILL ? ERR_SIZE : mis ? ERR_MISALIGN : oor ? ERR_ACCESS : ERR_NONE;
    err      = err_code != ERR_NONE;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller in front of DMEM.
// Ports: clk, rst_n; req_* from EX (valid/ready); flush; resp_* to writeback
// (valid/ready); err_count saturating fault counter; dmem_* control to DMEM and
// dmem_read_data back from it.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  output logic [7:0]  err_count,
  output logic        dmem_write_en,
  output logic        dmem_sign_extend,
  output logic [1:0]  dmem_size,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_write_data,
  input  logic [31:0] dmem_read_data
);
  state_e      state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_err_q, resp_err_d;
  logic [1:0]  resp_err_code_q, resp_err_code_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        chk_err;
  logic [1:0]  chk_code;
  logic        acc;

  lsu_align_check #(.DMEM_BASE(DMEM_BASE), .DMEM_BYTES(DMEM_BYTES)) u_chk (
    .size     (req_size),
    .addr     (req_addr),
    .err      (chk_err),
    .err_code (chk_code)
  );

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    uns_d           = uns_q;
    size_d          = size_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    resp_rdata_d    = resp_rdata_q;
    resp_rd_d       = resp_rd_q;
    resp_err_d      = resp_err_q;
    resp_err_code_d = resp_err_code_q;
    err_count_d     = err_count_q;
    case (state_q)
      ST_IDLE: if (req_valid && !flush) begin
        we_d            = req_we;
        uns_d           = req_unsigned;
        size_d          = req_size;
        addr_d          = req_addr;
        wdata_d         = req_wdata;
        resp_rd_d       = req_rd;
        resp_rdata_d    = '0;
        resp_err_d      = chk_err;
        resp_err_code_d = chk_code;
        state_d         = chk_err ? ST_RESP : ST_ACCESS;
        err_count_d     = (chk_err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
      end
      ST_ACCESS: begin
        state_d      = flush ? ST_IDLE : ST_RESP;
        resp_rdata_d = we_q ? '0 : dmem_read_data;
      end
      ST_RESP: state_d = (flush || resp_ready) ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      we_q            <= 1'b0;
      uns_q           <= 1'b0;
      size_q          <= SZ_BYTE;
      addr_q          <= '0;
      wdata_q         <= '0;
      resp_rdata_q    <= '0;
      resp_rd_q       <= '0;
      resp_err_q      <= 1'b0;
      resp_err_code_q <= ERR_NONE;
      err_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      uns_q           <= uns_d;
      size_q          <= size_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_rd_q       <= resp_rd_d;
      resp_err_q      <= resp_err_d;
      resp_err_code_q <= resp_err_code_d;
      err_count_q     <= err_count_d;
    end
  end

  // DMEM is only driven in ACCESS; the flush mask on write_en cancels a store in that same cycle.
  assign acc              = state_q == ST_ACCESS;
  assign req_ready        = state_q == ST_IDLE;
  assign resp_valid       = state_q == ST_RESP;
  assign resp_rdata       = resp_rdata_q;
  assign resp_rd          = resp_rd_q;
  assign resp_err         = resp_err_q;
  assign resp_err_code    = resp_err_code_q;
  assign err_count        = err_count_q;
  assign dmem_write_en    = acc && we_q && !flush;
  assign dmem_sign_extend = acc && !we_q && !uns_q;
  assign dmem_size        = acc ? size_q : SZ_BYTE;
  assign dmem_addr        = acc ? addr_q - DMEM_BASE : '0;
  assign dmem_write_data  = acc ? wdata_q : '0;
endmodule
